registers: RTL and testbench
============================

REGISTERS -- requirements
Module: registers

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data width of each register.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width.
REQ-003 Parameter DEPTH, default 8 (2**ADDR_W), SHALL set the number of registers.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 addr1  input  ADDR_W  SHALL select the register for read port 1.
REQ-007 addr2  input  ADDR_W  SHALL select the register for read port 2.
REQ-008 wr_addr  input  ADDR_W  SHALL select the register for the write port.
REQ-009 rd  input  1  SHALL be the read enable shared by both read ports.
REQ-010 wr  input  1  SHALL be the write enable.
REQ-011 data_in  input  DATA_W  SHALL carry the write data.
REQ-012 data_out1  output  DATA_W  SHALL carry the read data of port 1.
REQ-013 data_out2  output  DATA_W  SHALL carry the read data of port 2.

Function
REQ-014 Storage SHALL be DEPTH registers of DATA_W bits each; there are no hardwired-constant registers.
REQ-015 Write: on a rising clk edge with rst=0 and wr=1, reg[wr_addr] SHALL load data_in; all other registers hold their values.
REQ-016 With wr=0, no register SHALL change.
REQ-017 Reads SHALL be combinational (zero-cycle latency): with rd=1, data_out1=reg[addr1] and data_out2=reg[addr2], and both ports may read any address, including the same address.
REQ-018 With rd=0, data_out1 and data_out2 SHALL both be 0.
REQ-019 Write-through bypass: when rd=1, wr=1, rst=0 and addrN==wr_addr, data_outN SHALL equal data_in combinationally, independently per port.
REQ-020 After the write edge, the stored value SHALL equal the bypassed value, so the output does not glitch across the edge.
REQ-021 Read and write SHALL be independent; rd and wr may both be 1 in the same cycle.
REQ-022 Any X or Z on addresses or enables SHALL NOT corrupt unaddressed registers; registers are written only when wr is a known 1.
REQ-023 Address decoding SHALL cover all 2**ADDR_W values with no out-of-range case when DEPTH=2**ADDR_W.

Reset
REQ-024 On a rising clk edge with rst=1, all registers SHALL clear to 0.
REQ-025 rst SHALL take priority over wr; a write in the same cycle as reset is discarded.
REQ-026 While rst=1, the bypass SHALL be disabled, and data_outN SHALL read the stored values (0 after the first reset edge) when rd=1.
REQ-027 Until the first reset edge, register contents SHALL be undefined; the bench applies reset before checking data.
REQ-028 A reset asserted mid-operation SHALL take effect at the next rising edge only, with no asynchronous effect.

Verification
REQ-029 Reset, then rd=1, addr1=0, addr2=1 -> data_out1=0 and data_out2=0.
REQ-030 Write 0x00 to reg0 and 0x05 to reg1 (wr=1 for one edge each), then wr=0, rd=1, addr1=0, addr2=1 -> data_out1=0x00 and data_out2=0x05.
REQ-031 Write 0xA0+i to reg i for i=0..7, then sweep addr1=i and addr2=7-i -> data_out1=0xA0+i and data_out2=0xA7-i; with rd=0 -> both outputs 0.
REQ-032 With reg3=0x11, drive wr=1, wr_addr=3, data_in=0x22, rd=1, addr1=3, addr2=4 -> data_out1=0x22 before the edge; after the edge with wr=0 -> data_out1=0x22; data_out2 is unchanged.
REQ-033 Drive rst=1 and wr=1 with wr_addr=2, data_in=0xFF in the same cycle -> reg2=0 after the edge; then apply reset after a full fill -> all eight registers read 0.
REQ-034 Set addr1=addr2=5 with reg5=0x5A -> both outputs 0x5A.

Source files
------------

// File: rtl/registers.sv
// Register file with DEPTH x DATA_W storage, two combinational read ports
// and one synchronous write port with write-through bypass.
module registers #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2
);

  logic [DATA_W-1:0] regs [DEPTH];

  // Bypass is only live when the write will actually land at the next edge.
  logic bypass1;
  logic bypass2;

  // Storage update: reset clears everything and wins over a write; a write
  // needs a known-1 enable and an exact address match, so X/Z inputs leave
  // every register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if ((wr == 1'b1) && (wr_addr == ADDR_W'(i))) begin
          regs[i] <= data_in;
        end
      end
    end
  end

  // Read ports: zero when disabled, else stored value or in-flight write data.
  always_comb begin
    bypass1   = 1'b0;
    bypass2   = 1'b0;
    data_out1 = '0;
    data_out2 = '0;
    if (rd) begin
      bypass1   = wr && !rst && (addr1 == wr_addr);
      bypass2   = wr && !rst && (addr2 == wr_addr);
      data_out1 = bypass1 ? data_in : regs[addr1];
      data_out2 = bypass2 ? data_in : regs[addr2];
    end
  end

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for registers: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_registers;

  logic       clk;
  logic       rst;
  logic [2:0] addr1;
  logic [2:0] addr2;
  logic [2:0] wr_addr;
  logic       rd;
  logic       wr;
  logic [7:0] data_in;
  logic [7:0] data_out1;
  logic [7:0] data_out2;

  int total;
  int bad;

  logic [7:0] mem [8];

  registers #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr1    (addr1),
    .addr2    (addr2),
    .wr_addr  (wr_addr),
    .rd       (rd),
    .wr       (wr),
    .data_in  (data_in),
    .data_out1(data_out1),
    .data_out2(data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected read value for an address given the current inputs.
  function automatic logic [7:0] expect_rd(input logic [2:0] a);
    if (!rd) return 8'h00;
    if (wr && !rst && (a == wr_addr)) return data_in;
    return mem[a];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                       input logic [7:0] din, input logic re,
                       input logic [2:0] a1, input logic [2:0] a2);
    rst = r; wr = w; wr_addr = wa; data_in = din; rd = re; addr1 = a1; addr2 = a2;
  endtask

  // Check both ports before the edge, then advance one clock and the model.
  task automatic step(input string tag);
    #1;
    check({tag, "_p1"}, data_out1, expect_rd(addr1));
    check({tag, "_p2"}, data_out2, expect_rd(addr2));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    end else if (wr) begin
      mem[wr_addr] = data_in;
    end
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
    @(posedge clk);
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    #1;

    // Reset state, read while reset still held, then after release.
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd1);
    step("rst_hold");
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd1);
    #1;
    check("reset_r0", data_out1, 8'h00);
    check("reset_r1", data_out2, 8'h00);
    step("reset_rd");

    // Two simple writes then readback.
    drive(1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0); step("wr0");
    drive(1'b0, 1'b1, 3'd1, 8'h05, 1'b0, 3'd0, 3'd0); step("wr1");
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd1);
    #1;
    check("rb_r0", data_out1, 8'h00);
    check("rb_r1", data_out2, 8'h05);
    step("rb");

    // Fill A0+i and cross sweep.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 8'(8'hA0 + i), 1'b0, 3'd0, 3'd0);
      step("fill");
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 3'(7 - i));
      #1;
      check("sweep1", data_out1, 8'(8'hA0 + i));
      check("sweep2", data_out2, 8'(8'hA7 - i));
      step("sweep");
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd6);
    #1;
    check("rd0_p1", data_out1, 8'h00);
    check("rd0_p2", data_out2, 8'h00);
    step("rd0");

    // Bypass on port 1 only, and no glitch across the write edge.
    drive(1'b0, 1'b1, 3'd3, 8'h11, 1'b0, 3'd0, 3'd0); step("set3");
    drive(1'b0, 1'b1, 3'd3, 8'h22, 1'b1, 3'd3, 3'd4);
    #1;
    check("byp_p1", data_out1, 8'h22);
    check("byp_p2", data_out2, 8'hA4);
    step("byp");
    drive(1'b0, 1'b0, 3'd3, 8'h22, 1'b1, 3'd3, 3'd4);
    #1;
    check("post_p1", data_out1, 8'h22);
    check("post_p2", data_out2, 8'hA4);
    step("post");

    // Reset beats a same-cycle write; bypass off during reset.
    drive(1'b1, 1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 3'd3);
    #1;
    check("rstwr_p1", data_out1, 8'hA2);
    step("rstwr");
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd3);
    #1;
    check("rstwr_r2", data_out1, 8'h00);
    step("rstwr_after");

    // Full fill then reset clears all.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 8'($urandom_range(1, 255)), 1'b0, 3'd0, 3'd0);
      step("fill2");
    end
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0); step("rst2");
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 3'(i));
      #1;
      check("clr", data_out1, 8'h00);
      step("clr");
    end

    // Same address on both ports.
    drive(1'b0, 1'b1, 3'd5, 8'h5A, 1'b0, 3'd0, 3'd0); step("set5");
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd5);
    #1;
    check("same_p1", data_out1, 8'h5A);
    check("same_p2", data_out2, 8'h5A);
    step("same");

    // Random traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] wa;
      logic [2:0] a1;
      logic [2:0] a2;
      wa = 3'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), wa,
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), a1, a2);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
